// File: rtl/w0rm_mem_arbiter_if.sv
// Bundle of the requester, memory and status signals around w0rm_mem_arbiter.
// slave = arbiter view, master = view of the surrounding requesters and memory.
interface w0rm_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_req_ready;
  logic                  if_resp_valid;
  logic [DATA_WIDTH-1:0] if_resp_data;

  logic                  dm_req_valid;
  logic                  dm_req_wr;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic [DATA_WIDTH-1:0] dm_req_wdata;
  logic                  dm_req_ready;
  logic                  dm_resp_valid;
  logic [DATA_WIDTH-1:0] dm_resp_data;

  logic                  mem_valid;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req_valid, if_req_addr,
    output if_req_ready, if_resp_valid, if_resp_data,
    input  dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata,
    output dm_req_ready, dm_resp_valid, dm_resp_data,
    output mem_valid, mem_wr, mem_addr, mem_wdata,
    input  mem_ready, mem_resp_valid, mem_rdata,
    output busy
  );

  modport master (
    output if_req_valid, if_req_addr,
    input  if_req_ready, if_resp_valid, if_resp_data,
    output dm_req_valid, dm_req_wr, dm_req_addr, dm_req_wdata,
    input  dm_req_ready, dm_resp_valid, dm_resp_data,
    input  mem_valid, mem_wr, mem_addr, mem_wdata,
    output mem_ready, mem_resp_valid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/w0rm_mem_arbiter.sv
// Shares one memory port between instruction fetch (IF) and data memory (DM), DM first.
// Define W0RM_MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT DM grants.
module w0rm_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  w0rm_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  owner_dm_q;
  logic                  mem_valid_q;
  logic                  mem_wr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  if_resp_valid_q;
  logic [DATA_WIDTH-1:0] if_resp_data_q;
  logic                  dm_resp_valid_q;
  logic [DATA_WIDTH-1:0] dm_resp_data_q;

  logic idle_ok;
  logic force_if;
  logic grant_dm;
  logic grant_if;
  logic complete;

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign idle_ok  = reset && (state_q == IDLE);
  assign grant_dm = idle_ok && bus.dm_req_valid && !force_if;
  assign grant_if = idle_ok && bus.if_req_valid && (!bus.dm_req_valid || force_if);

  assign complete = ((state_q == ISSUE) && bus.mem_ready && bus.mem_resp_valid) ||
                    ((state_q == WAIT) && bus.mem_resp_valid);

`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
  localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

  logic [3:0] starve_q;
  logic [3:0] starve_d;

  assign force_if = (starve_q == STARVE_LIMIT_C) && bus.if_req_valid && bus.dm_req_valid;

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (grant_if || !bus.if_req_valid) begin
        starve_d = 4'd0;
      end else if (grant_dm) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      owner_dm_q      <= 1'b0;
      mem_valid_q     <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      if_resp_valid_q <= 1'b0;
      if_resp_data_q  <= '0;
      dm_resp_valid_q <= 1'b0;
      dm_resp_data_q  <= '0;
    end else begin
      if_resp_valid_q <= 1'b0;
      dm_resp_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (grant_dm || grant_if) begin
            state_q     <= ISSUE;
            owner_dm_q  <= grant_dm;
            mem_valid_q <= 1'b1;
            mem_wr_q    <= grant_dm && bus.dm_req_wr;
            mem_addr_q  <= grant_dm ? bus.dm_req_addr : bus.if_req_addr;
            mem_wdata_q <= grant_dm ? bus.dm_req_wdata : '0;
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= bus.mem_resp_valid ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_resp_valid) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_valid_q <= 1'b0;
        end
      endcase

      // Response goes only to the requester that owns the transaction.
      if (complete) begin
        if (owner_dm_q) begin
          dm_resp_valid_q <= 1'b1;
          dm_resp_data_q  <= mem_wr_q ? '0 : bus.mem_rdata;
        end else begin
          if_resp_valid_q <= 1'b1;
          if_resp_data_q  <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_req_ready  = grant_if;
  assign bus.dm_req_ready  = grant_dm;
  assign bus.if_resp_valid = if_resp_valid_q;
  assign bus.if_resp_data  = if_resp_data_q;
  assign bus.dm_resp_valid = dm_resp_valid_q;
  assign bus.dm_resp_data  = dm_resp_data_q;
  assign bus.mem_valid     = mem_valid_q;
  assign bus.mem_wr        = mem_wr_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.busy          = (state_q != IDLE);

`ifndef SYNTHESIS
  a_limit_range: assert property (@(posedge clk) (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

  a_one_ready: assert property (@(posedge clk) !(bus.if_req_ready && bus.dm_req_ready));

  a_ready_idle: assert property (@(posedge clk)
    (bus.if_req_ready || bus.dm_req_ready) |-> (state_q == IDLE));

  a_req_stable: assert property (@(posedge clk) disable iff (!reset)
    (bus.mem_valid && !bus.mem_ready) |=>
      (bus.mem_valid && $stable(bus.mem_addr) && $stable(bus.mem_wr) && $stable(bus.mem_wdata)));

  a_resp_exclusive: assert property (@(posedge clk) !(bus.if_resp_valid && bus.dm_resp_valid));
`endif

endmodule

// File: tb/tb_w0rm_mem_arbiter.sv
// Randomized bench for w0rm_mem_arbiter: a transaction-level model predicts grants,
// memory requests and routed responses; directed phases cover reset, stalls and contention.
module tb_w0rm_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  w0rm_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  w0rm_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int n_txn    = 0;

  // Requester state: a pending request is held until it is granted.
  bit          if_pend, dm_pend, dm_wr;
  logic [31:0] if_addr, dm_addr, dm_wdata;

  // Model of the single transaction in flight and of the response due next cycle.
  bit          m_busy, m_acc, m_own_dm, m_wr;
  logic [31:0] m_addr, m_wdata;
  bit          m_due, m_due_dm;
  logic [31:0] m_due_data;
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
  int          m_starve;
`endif
  int          g_log[$];

  // Stimulus knobs (percentages).
  int          p_if, p_dm, p_rdy, p_resp, p_spur;
  bit          fast, rst_req, rdata_fix_en;
  logic [31:0] rdata_fix;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    bit g_if, g_dm, force_if;
    @(negedge clk);
    check("if_resp_valid", 32'(bus.if_resp_valid), 32'(m_due && !m_due_dm));
    check("dm_resp_valid", 32'(bus.dm_resp_valid), 32'(m_due && m_due_dm));
    if (m_due && m_due_dm) check("dm_resp_data", bus.dm_resp_data, m_due_data);
    if (m_due && !m_due_dm) check("if_resp_data", bus.if_resp_data, m_due_data);
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("mem_valid", 32'(bus.mem_valid), 32'(m_busy && !m_acc));
    if (m_busy && !m_acc) begin
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wr", 32'(bus.mem_wr), 32'(m_wr));
      if (m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
    end

    if (!if_pend && ($urandom_range(99) < p_if)) begin
      if_pend = 1'b1;
      if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!dm_pend && ($urandom_range(99) < p_dm)) begin
      dm_pend  = 1'b1;
      dm_wr    = 1'($urandom_range(1));
      dm_addr  = $urandom;
      dm_wdata = $urandom;
    end
    rst_n            = !rst_req;
    bus.if_req_valid = if_pend;
    bus.if_req_addr  = if_addr;
    bus.dm_req_valid = dm_pend;
    bus.dm_req_wr    = dm_wr;
    bus.dm_req_addr  = dm_addr;
    bus.dm_req_wdata = dm_wdata;
    bus.mem_rdata    = rdata_fix_en ? rdata_fix : $urandom;
    if (fast) begin
      bus.mem_ready      = 1'b1;
      bus.mem_resp_valid = 1'b1;
    end else begin
      bus.mem_ready = ($urandom_range(99) < p_rdy);
      if (!m_busy)     bus.mem_resp_valid = ($urandom_range(99) < p_spur);
      else if (!m_acc) bus.mem_resp_valid = bus.mem_ready && ($urandom_range(99) < p_resp);
      else             bus.mem_resp_valid = ($urandom_range(99) < p_resp);
    end

    #1;
    force_if = 1'b0;
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
    force_if = (m_starve == SL) && if_pend && dm_pend;
`endif
    g_dm = rst_n && !m_busy && dm_pend && !force_if;
    g_if = rst_n && !m_busy && if_pend && !g_dm;
    check("if_req_ready", 32'(bus.if_req_ready), 32'(g_if));
    check("dm_req_ready", 32'(bus.dm_req_ready), 32'(g_dm));

    m_due = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_acc  = 1'b0;
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
      m_starve = 0;
`endif
    end else if (!m_busy) begin
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
      if (g_if || !if_pend) m_starve = 0;
      else if (g_dm)        m_starve++;
`endif
      if (g_dm || g_if) begin
        m_busy   = 1'b1;
        m_acc    = 1'b0;
        m_own_dm = g_dm;
        m_wr     = g_dm && dm_wr;
        m_addr   = g_dm ? dm_addr : if_addr;
        m_wdata  = dm_wdata;
        g_log.push_back(g_if ? 1 : 0);
        if (g_dm) dm_pend = 1'b0;
        else      if_pend = 1'b0;
      end
    end else if (!m_acc) begin
      if (bus.mem_ready) begin
        m_acc = 1'b1;
        if (bus.mem_resp_valid) complete_txn();
      end
    end else if (bus.mem_resp_valid) begin
      complete_txn();
    end
  endtask

  task automatic complete_txn();
    m_due      = 1'b1;
    m_due_dm   = m_own_dm;
    m_due_data = (m_own_dm && m_wr) ? 32'h0 : bus.mem_rdata;
    m_busy     = 1'b0;
    n_txn++;
    $display("txn %0d: %s %s addr=%08h data=%08h", n_txn, m_own_dm ? "DM" : "IF",
             m_wr ? "WR" : "RD", m_addr, m_wr ? m_wdata : m_due_data);
  endtask

  task automatic drain();
    int n;
    p_if = 0;
    p_dm = 0;
    n = 0;
    while ((m_busy || if_pend || dm_pend) && (n < 500)) begin
      step();
      n++;
    end
    check("drain_in_budget", 32'(n < 500), 32'd1);
    step();
  endtask

  initial begin
    int exp_if;
    int n;
    p_if = 0; p_dm = 0; p_rdy = 100; p_resp = 100; p_spur = 0;
    fast = 1'b1; rst_req = 1'b0; rdata_fix_en = 1'b0; rdata_fix = 32'h0;
    m_busy = 1'b0; m_acc = 1'b0; m_due = 1'b0; m_due_dm = 1'b0; m_own_dm = 1'b0; m_wr = 1'b0;
    m_addr = '0; m_wdata = '0; m_due_data = '0;
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif

    // Reset held for 3 cycles with both requesters valid.
    if_pend = 1'b1; if_addr = 32'h0000_0040;
    dm_pend = 1'b1; dm_wr = 1'b0; dm_addr = 32'h0000_0080; dm_wdata = 32'h0;
    rst_n = 1'b0;
    bus.if_req_valid = 1'b1; bus.if_req_addr = if_addr;
    bus.dm_req_valid = 1'b1; bus.dm_req_wr = 1'b0; bus.dm_req_addr = dm_addr; bus.dm_req_wdata = 32'h0;
    bus.mem_ready = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hA5A5_A5A5;
    repeat (3) @(negedge clk);
    check("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_if_resp", {31'd0, bus.if_resp_valid} | bus.if_resp_data, 32'd0);
    check("rst_dm_resp", {31'd0, bus.dm_resp_valid} | bus.dm_resp_data, 32'd0);
    check("rst_if_ready", 32'(bus.if_req_ready), 32'd0);
    check("rst_dm_ready", 32'(bus.dm_req_ready), 32'd0);

    // Release: DM wins the first IDLE cycle, IF follows.
    step();
    drain();

    // IF read answered in the same cycle it is accepted by memory.
    if_pend = 1'b1; if_addr = 32'h0000_0100;
    fast = 1'b1; rdata_fix_en = 1'b1; rdata_fix = 32'hDEAD_BEEF;
    drain();
    rdata_fix_en = 1'b0;

    // DM write with memory stalling for 3 cycles.
    dm_pend = 1'b1; dm_wr = 1'b1; dm_addr = 32'h0000_2000; dm_wdata = 32'h1234_5678;
    fast = 1'b0; p_rdy = 0; p_resp = 50; p_spur = 0;
    repeat (4) step();
    p_rdy = 100;
    drain();

    // Contention with single-cycle memory.
    g_log.delete();
    fast = 1'b1; p_if = 100; p_dm = 100;
    n = 0;
    while ((g_log.size() < 20) && (n < 300)) begin
      step();
      n++;
    end
    check("contention_in_budget", 32'(g_log.size() >= 20), 32'd1);
    for (int k = 0; k < 20 && k < g_log.size(); k++) begin
`ifdef W0RM_MEM_ARB_STARVE_GUARD_EN
      exp_if = ((k % 5) == 4) ? 1 : 0;
`else
      exp_if = 0;
`endif
      check("contention_grant_is_if", 32'(g_log[k]), 32'(exp_if));
    end
    drain();

    // Reset while DM owns the port and waits for its response.
    dm_pend = 1'b1; dm_wr = 1'b0; dm_addr = 32'h0000_3000;
    fast = 1'b0; p_rdy = 100; p_resp = 0; p_spur = 0;
    repeat (3) step();
    check("midrst_in_wait", 32'(m_busy && m_acc), 32'd1);
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    p_resp = 100; p_spur = 100;
    repeat (3) step();
    drain();

    // IF then DM one cycle apart.
    fast = 1'b1; p_spur = 0;
    if_pend = 1'b1; if_addr = 32'h0000_0400;
    step();
    dm_pend = 1'b1; dm_wr = 1'b1; dm_addr = 32'h0000_0500; dm_wdata = 32'hCAFE_F00D;
    drain();

    // Randomized traffic.
    fast = 1'b0; p_if = 40; p_dm = 40; p_rdy = 60; p_resp = 50; p_spur = 30;
    repeat (3000) step();
    p_rdy = 100; p_resp = 100;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
